// File: rtl/sim_mgt_loopback_pkg.sv
// Shared constants and helpers for the loopback MGT bank model.
package sim_mgt_loopback_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned LANE_W    = 16;

   localparam logic [7:0] K28_5  = 8'hBC;
   localparam logic [7:0] CHAR_A = 8'h7C;
   localparam logic [7:0] CHAR_K = 8'hBC;
   localparam logic [7:0] CHAR_R = 8'h1C;

   // True when byte b is the K character c.
   function automatic logic is_kchar(input logic [7:0] b, input logic k, input logic [7:0] c);
      return k && (b == c);
   endfunction

   // Largest 2-bit skew field of a packed 4-lane skew vector.
   function automatic logic [1:0] max_skew(input logic [7:0] skew);
      logic [1:0] m;
      m = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (skew[2*i +: 2] > m) begin
            m = skew[2*i +: 2];
         end else begin
            m = m;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/sim_mgt_lane.sv
// One loopback lane: tx register, skew line, byte slip with comma
// alignment, receive lock counter and output flags.
module sim_mgt_lane
   import sim_mgt_loopback_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 16,
   parameter logic [1:0]  SKEW        = 2'd0,
   parameter logic [1:0]  MAX_SKEW    = 2'd0,
   parameter logic        SLIP_INIT   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LANE_W-1:0] tx_data,
   input  logic [1:0]        tx_charisk,
   input  logic              tx_reset,
   input  logic              rx_reset,
   input  logic              enable_align,
   input  logic              bonded,
   output logic [LANE_W-1:0] rx_data,
   output logic [1:0]        rx_charisk,
   output logic [1:0]        codevalid,
   output logic [1:0]        codecomma,
   output logic              rxlock,
   output logic              a_hit
);

   localparam int unsigned    CNT_W     = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

   logic [LANE_W-1:0] pipe_d_r [0:3];
   logic [1:0]        pipe_k_r [0:3];
   logic [LANE_W-1:0] prev_d_r;
   logic [1:0]        prev_k_r;
   logic              slip_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              lock_r;

   logic [1:0]        tap_s;
   logic [LANE_W-1:0] cur_d_s;
   logic [1:0]        cur_k_s;
   logic [LANE_W-1:0] post_d_s;
   logic [1:0]        post_k_s;
   logic              align_hit_s;
   logic              lock_nxt_s;

   // Tx register (stage 0) followed by the skew shift line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            pipe_d_r[k] <= 16'h0000;
            pipe_k_r[k] <= 2'b00;
         end
      end else begin
         pipe_d_r[0] <= tx_reset ? 16'h0000 : tx_data;
         pipe_k_r[0] <= tx_reset ? 2'b00 : tx_charisk;
         for (int k = 1; k < 4; k++) begin
            pipe_d_r[k] <= pipe_d_r[k-1];
            pipe_k_r[k] <= pipe_k_r[k-1];
         end
      end
   end

   // Bonding replaces the lane's own skew with the bank-wide maximum.
   always_comb begin
      tap_s = SKEW;
      if (bonded) begin
         tap_s = MAX_SKEW;
      end else begin
         tap_s = SKEW;
      end
      cur_d_s = pipe_d_r[tap_s];
      cur_k_s = pipe_k_r[tap_s];
   end

   // Byte framing: a slipped lane pairs the current low byte with the previous high byte.
   always_comb begin
      post_d_s = cur_d_s;
      post_k_s = cur_k_s;
      if (slip_r) begin
         post_d_s = {cur_d_s[7:0], prev_d_r[15:8]};
         post_k_s = {cur_k_s[0], prev_k_r[1]};
      end else begin
         post_d_s = cur_d_s;
         post_k_s = cur_k_s;
      end
      align_hit_s = enable_align && is_kchar(post_d_s[15:8], post_k_s[1], K28_5);
      a_hit       = is_kchar(post_d_s[7:0], post_k_s[0], CHAR_A) && !align_hit_s;
      lock_nxt_s  = !rx_reset && (lock_r || (cnt_r == LOCK_LAST));
   end

   // Previous-word holder and slip state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_d_r <= 16'h0000;
         prev_k_r <= 2'b00;
         slip_r   <= SLIP_INIT;
      end else begin
         prev_d_r <= cur_d_s;
         prev_k_r <= cur_k_s;
         if (rx_reset) begin
            slip_r <= SLIP_INIT;
         end else if (align_hit_s) begin
            slip_r <= ~slip_r;
         end else begin
            slip_r <= slip_r;
         end
      end
   end

   // Receive lock counter; saturates once lock is reached.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r  <= '0;
         lock_r <= 1'b0;
      end else begin
         lock_r <= lock_nxt_s;
         if (rx_reset) begin
            cnt_r <= '0;
         end else if (!lock_r) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Output register; an unlocked lane presents all zeros.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data    <= 16'h0000;
         rx_charisk <= 2'b00;
         codevalid  <= 2'b00;
         codecomma  <= 2'b00;
      end else if (lock_nxt_s) begin
         rx_data    <= post_d_s;
         rx_charisk <= post_k_s;
         codevalid  <= 2'b11;
         codecomma  <= {is_kchar(post_d_s[15:8], post_k_s[1], K28_5),
                        is_kchar(post_d_s[7:0],  post_k_s[0], K28_5)};
      end else begin
         rx_data    <= 16'h0000;
         rx_charisk <= 2'b00;
         codevalid  <= 2'b00;
         codecomma  <= 2'b00;
      end
   end

   assign rxlock = lock_r;

endmodule

// File: rtl/sim_mgt_loopback.sv
// Four-lane MGT bank in serial loopback with skew, slip, comma alignment
// and channel bonding, for closing the loop around the XAUI PCS.
module sim_mgt_loopback
   import sim_mgt_loopback_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 16,
   parameter logic [7:0]  LANE_SKEW   = 8'b11_10_01_00,
   parameter logic [3:0]  LANE_SLIP   = 4'b1010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] mgt_txdata,
   input  logic [7:0]  mgt_txcharisk,
   input  logic [3:0]  mgt_tx_reset,
   input  logic [3:0]  mgt_rx_reset,
   input  logic [3:0]  mgt_enable_align,
   input  logic        mgt_enchansync,
   output logic [63:0] mgt_rxdata,
   output logic [7:0]  mgt_rxcharisk,
   output logic [7:0]  mgt_codevalid,
   output logic [7:0]  mgt_codecomma,
   output logic [3:0]  mgt_rxlock
);

   localparam logic [1:0] MAX_SKEW = max_skew(LANE_SKEW);

   logic [3:0] a_hit_s;
   logic [3:0] seen_r;
   logic       bonded_r;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      sim_mgt_lane #(
         .LOCK_CYCLES (LOCK_CYCLES),
         .SKEW        (LANE_SKEW[2*i+1:2*i]),
         .MAX_SKEW    (MAX_SKEW),
         .SLIP_INIT   (LANE_SLIP[i])
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .tx_data      (mgt_txdata[16*i +: 16]),
         .tx_charisk   (mgt_txcharisk[2*i +: 2]),
         .tx_reset     (mgt_tx_reset[i]),
         .rx_reset     (mgt_rx_reset[i]),
         .enable_align (mgt_enable_align[i]),
         .bonded       (bonded_r),
         .rx_data      (mgt_rxdata[16*i +: 16]),
         .rx_charisk   (mgt_rxcharisk[2*i +: 2]),
         .codevalid    (mgt_codevalid[2*i +: 2]),
         .codecomma    (mgt_codecomma[2*i +: 2]),
         .rxlock       (mgt_rxlock[i]),
         .a_hit        (a_hit_s[i])
      );
   end

   // Channel bonding: collect /A/ sightings until every lane has reported one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seen_r   <= 4'b0000;
         bonded_r <= 1'b0;
      end else if ((|mgt_rx_reset) || !mgt_enchansync) begin
         seen_r   <= 4'b0000;
         bonded_r <= 1'b0;
      end else begin
         seen_r <= seen_r | a_hit_s;
         if (&(seen_r | a_hit_s)) begin
            bonded_r <= 1'b1;
         end else begin
            bonded_r <= bonded_r;
         end
      end
   end

endmodule

// File: tb/tb_sim_mgt_loopback.sv
// Directed bench: table-driven lock/align phase plus hand sequences for
// skew, bonding, per-lane rx reset and tx reset.
module tb_sim_mgt_loopback;

   logic        clk;
   logic        reset;
   logic [63:0] mgt_txdata;
   logic [7:0]  mgt_txcharisk;
   logic [3:0]  mgt_tx_reset;
   logic [3:0]  mgt_rx_reset;
   logic [3:0]  mgt_enable_align;
   logic        mgt_enchansync;
   logic [63:0] mgt_rxdata;
   logic [7:0]  mgt_rxcharisk;
   logic [7:0]  mgt_codevalid;
   logic [7:0]  mgt_codecomma;
   logic [3:0]  mgt_rxlock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] hist_w [0:127];
   logic [1:0]  hist_k [0:127];
   logic [3:0]  hist_t [0:127];

   typedef struct {
      int          steps;
      logic [3:0]  align;
      logic [63:0] data;
      logic [7:0]  k;
      logic [7:0]  comma;
      logic [7:0]  valid;
      logic [3:0]  lock;
   } vec_t;

   vec_t vecs [10];

   sim_mgt_loopback dut (
      .clk              (clk),
      .reset            (reset),
      .mgt_txdata       (mgt_txdata),
      .mgt_txcharisk    (mgt_txcharisk),
      .mgt_tx_reset     (mgt_tx_reset),
      .mgt_rx_reset     (mgt_rx_reset),
      .mgt_enable_align (mgt_enable_align),
      .mgt_enchansync   (mgt_enchansync),
      .mgt_rxdata       (mgt_rxdata),
      .mgt_rxcharisk    (mgt_rxcharisk),
      .mgt_codevalid    (mgt_codevalid),
      .mgt_codecomma    (mgt_codecomma),
      .mgt_rxlock       (mgt_rxlock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [63:0] d, input logic [7:0] k,
                            input logic [7:0] c, input logic [7:0] v, input logic [3:0] l);
      check({tag, ".rxdata"},    mgt_rxdata,    d);
      check({tag, ".rxcharisk"}, {56'd0, mgt_rxcharisk}, {56'd0, k});
      check({tag, ".codecomma"}, {56'd0, mgt_codecomma}, {56'd0, c});
      check({tag, ".codevalid"}, {56'd0, mgt_codevalid}, {56'd0, v});
      check({tag, ".rxlock"},    {60'd0, mgt_rxlock},    {60'd0, l});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the same word on all lanes for one cycle and log it.
   task automatic run_cycle(input logic [15:0] w, input logic [1:0] kk);
      mgt_txdata    = {4{w}};
      mgt_txcharisk = {4{kk}};
      hist_w[cyc] = w;
      hist_k[cyc] = kk;
      hist_t[cyc] = mgt_tx_reset;
      tick();
      cyc++;
   endtask

   // Expected rx after edge m: lane i shows the word sampled at edge m-1-delay.
   task automatic expect_rx(input int m, input logic bonded_e, input logic [3:0] on,
                            output logic [63:0] d, output logic [7:0] k);
      int idx;
      d = 64'd0;
      k = 8'd0;
      for (int i = 0; i < 4; i++) begin
         idx = m - 1 - (bonded_e ? 3 : i);
         if (on[i] && !hist_t[idx][i]) begin
            d[16*i +: 16] = hist_w[idx];
            k[2*i +: 2]   = hist_k[idx];
         end
      end
   endtask

   logic [63:0] ed;
   logic [7:0]  ek;
   logic [3:0]  on;
   logic [7:0]  ev;

   initial begin
      vecs[0] = '{1,  4'h0, 64'h0, 8'h00, 8'h00, 8'h00, 4'h0};
      vecs[1] = '{14, 4'h0, 64'h0, 8'h00, 8'h00, 8'h00, 4'h0};
      vecs[2] = '{1,  4'h0, 64'hBC07_07BC_BC07_07BC, 8'h99, 8'h99, 8'hFF, 4'hF};
      vecs[3] = '{3,  4'h0, 64'hBC07_07BC_BC07_07BC, 8'h99, 8'h99, 8'hFF, 4'hF};
      vecs[4] = '{1,  4'hD, 64'hBC07_07BC_BC07_07BC, 8'h99, 8'h99, 8'hFF, 4'hF};
      vecs[5] = '{1,  4'hD, 64'h07BC_07BC_BC07_07BC, 8'h59, 8'h59, 8'hFF, 4'hF};
      vecs[6] = '{5,  4'hD, 64'h07BC_07BC_BC07_07BC, 8'h59, 8'h59, 8'hFF, 4'hF};
      vecs[7] = '{1,  4'hF, 64'h07BC_07BC_BC07_07BC, 8'h59, 8'h59, 8'hFF, 4'hF};
      vecs[8] = '{1,  4'hF, 64'h07BC_07BC_07BC_07BC, 8'h55, 8'h55, 8'hFF, 4'hF};
      vecs[9] = '{3,  4'hF, 64'h07BC_07BC_07BC_07BC, 8'h55, 8'h55, 8'hFF, 4'hF};

      reset            = 1'b0;
      mgt_txdata       = {4{16'h07BC}};
      mgt_txcharisk    = {4{2'b01}};
      mgt_tx_reset     = 4'h0;
      mgt_rx_reset     = 4'h0;
      mgt_enable_align = 4'h0;
      mgt_enchansync   = 1'b0;
      repeat (3) tick();
      check_all("reset", 64'h0, 8'h00, 8'h00, 8'h00, 4'h0);

      // Idle comma traffic: lock acquisition, then alignment of slipped lanes.
      reset = 1'b1;
      for (int v = 0; v < 10; v++) begin
         mgt_enable_align = vecs[v].align;
         for (int s = 0; s < vecs[v].steps; s++) begin
            tick();
            check_all($sformatf("vec%0d.%0d", v, s), vecs[v].data, vecs[v].k,
                      vecs[v].comma, vecs[v].valid, vecs[v].lock);
         end
      end
      mgt_enable_align = 4'h0;

      // Counter traffic: unbonded lane i lags by i cycles.
      cyc = 0;
      for (int n = 0; n < 12; n++) begin
         run_cycle(16'h1000 + cyc[15:0], 2'b00);
         if (cyc - 1 >= 4) begin
            expect_rx(cyc - 1, 1'b0, 4'hF, ed, ek);
            check($sformatf("skew.data%0d", cyc - 1), mgt_rxdata, ed);
            check($sformatf("skew.k%0d", cyc - 1), {56'd0, mgt_rxcharisk}, {56'd0, ek});
         end
      end

      // /A/ on all lanes; bonding takes effect once the slowest lane reports it.
      mgt_enchansync = 1'b1;
      run_cycle(16'h007C, 2'b01);
      for (int n = 13; n <= 30; n++) begin
         run_cycle(16'h1000 + cyc[15:0], 2'b00);
         expect_rx(cyc - 1, (cyc - 1) >= 17, 4'hF, ed, ek);
         check($sformatf("bond.data%0d", cyc - 1), mgt_rxdata, ed);
         check($sformatf("bond.k%0d", cyc - 1), {56'd0, mgt_rxcharisk}, {56'd0, ek});
      end

      // Dropping enchansync unbonds on the next edge.
      mgt_enchansync = 1'b0;
      for (int n = 31; n <= 36; n++) begin
         run_cycle(16'h1000 + cyc[15:0], 2'b00);
         expect_rx(cyc - 1, (cyc - 1) < 32, 4'hF, ed, ek);
         check($sformatf("unbond.data%0d", cyc - 1), mgt_rxdata, ed);
      end

      // Lane 2 rx reset for three cycles; relock 16 cycles after release.
      for (int n = 37; n <= 60; n++) begin
         mgt_rx_reset = (cyc >= 37 && cyc <= 39) ? 4'b0100 : 4'b0000;
         run_cycle(16'h1000 + cyc[15:0], 2'b00);
         on = ((cyc - 1) >= 37 && (cyc - 1) <= 54) ? 4'b1011 : 4'b1111;
         ev = {{2{on[3]}}, {2{on[2]}}, {2{on[1]}}, {2{on[0]}}};
         expect_rx(cyc - 1, 1'b0, on, ed, ek);
         check_all($sformatf("rxrst%0d", cyc - 1), ed, ek, 8'h00, ev, on);
      end

      // Lane 0 tx reset: zeros appear after the lane latency.
      for (int n = 61; n <= 72; n++) begin
         mgt_tx_reset = (cyc >= 61 && cyc <= 66) ? 4'b0001 : 4'b0000;
         run_cycle(16'h1000 + cyc[15:0], 2'b11);
         expect_rx(cyc - 1, 1'b0, 4'hF, ed, ek);
         check_all($sformatf("txrst%0d", cyc - 1), ed, ek, 8'h00, 8'hFF, 4'hF);
      end
      check("txrst.lane0_zero_seen", {48'd0, hist_w[62] & {16{~hist_t[62][0]}}}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
